// File: rtl/fifo_synch_if.sv
// Producer/consumer handshake bundle for fifo_synch.
// The master side is whoever drives the FIFO; the slave side is the FIFO itself.
interface fifo_synch_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
);
  logic [WIDTH-1:0]    inData;
  logic                inValid;
  logic                inReady;
  logic [WIDTH-1:0]    outData;
  logic                outValid;
  logic                outReady;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outValid, count, overflow
  );

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outValid, count, overflow
  );
endinterface

// File: rtl/fifo_synch.sv
// First-word-fall-through FIFO whose every state bit lives in a dff_synch cell.
// Handshakes are blocked while rstn is low, so a reset edge never pushes or pops.
module dff_synch #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  // Enabled flop with synchronous clear to zero
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;
endmodule

module fifo_synch #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rstn,
  fifo_synch_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      w_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_wr_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_ptr;
  logic [DEPTH_LOG2:0]   w_count;
  logic                  w_overflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  assign w_full  = (w_count == FULL_CNT);
  assign w_empty = (w_count == {(DEPTH_LOG2+1){1'b0}});

  assign bus.inReady  = rstn & ~w_full;
  assign bus.outValid = rstn & ~w_empty;
  assign w_push       = bus.inValid & bus.inReady;
  assign w_pop        = bus.outValid & bus.outReady;

  // Only one slot is written per push; pointer widths wrap modulo DEPTH on their own
  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    dff_synch #(.W(WIDTH)) u_slot (
      .clk (clk),
      .rstn(rstn),
      .en  (w_push & (w_wr_ptr == DEPTH_LOG2'(g))),
      .d   (bus.inData),
      .q   (w_mem[g])
    );
  end

  dff_synch #(.W(DEPTH_LOG2)) u_wr_ptr (
    .clk (clk),
    .rstn(rstn),
    .en  (w_push),
    .d   (w_wr_ptr + DEPTH_LOG2'(1)),
    .q   (w_wr_ptr)
  );

  dff_synch #(.W(DEPTH_LOG2)) u_rd_ptr (
    .clk (clk),
    .rstn(rstn),
    .en  (w_pop),
    .d   (w_rd_ptr + DEPTH_LOG2'(1)),
    .q   (w_rd_ptr)
  );

  // Count only moves when exactly one of push/pop happens
  assign w_count_nxt = w_push ? (w_count + (DEPTH_LOG2+1)'(1))
                              : (w_count - (DEPTH_LOG2+1)'(1));

  dff_synch #(.W(DEPTH_LOG2+1)) u_count (
    .clk (clk),
    .rstn(rstn),
    .en  (w_push ^ w_pop),
    .d   (w_count_nxt),
    .q   (w_count)
  );

  dff_synch #(.W(1)) u_overflow (
    .clk (clk),
    .rstn(rstn),
    .en  (bus.inValid & w_full),
    .d   (1'b1),
    .q   (w_overflow)
  );

  assign bus.outData  = w_mem[w_rd_ptr];
  assign bus.count    = w_count;
  assign bus.overflow = w_overflow;
endmodule

// File: tb/tb_fifo_synch.sv
// Randomised and directed bench for fifo_synch; a queue model tracks contents and
// a monitor compares the DUT against it one tick before every rising edge.
module tb_fifo_synch;
  localparam int WIDTH      = 16;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic rstn;

  fifo_synch_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) fif ();

  fifo_synch #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (fif)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf = 1'b0;
  logic             clean   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare just before each rising edge, then advance the model
  always begin
    @(negedge clk);
    #4;
    if (!rstn) begin
      chk("rst_inReady", 32'(fif.inReady), 32'd0);
      chk("rst_outValid", 32'(fif.outValid), 32'd0);
      exp_q.delete();
      exp_ovf = 1'b0;
      clean   = 1'b1;
    end else begin
      chk("count", 32'(fif.count), 32'(exp_q.size()));
      chk("outValid", 32'(fif.outValid), 32'(exp_q.size() != 0));
      chk("inReady", 32'(fif.inReady), 32'(exp_q.size() < DEPTH));
      chk("overflow", 32'(fif.overflow), 32'(exp_ovf));
      if (exp_q.size() != 0) begin
        chk("outData", 32'(fif.outData), 32'(exp_q[0]));
      end else if (clean) begin
        chk("outData_rst", 32'(fif.outData), 32'd0);
      end
      if (fif.inValid && exp_q.size() == DEPTH) begin
        exp_ovf = 1'b1;
      end
      if (fif.inValid && exp_q.size() < DEPTH) begin
        exp_q.push_back(fif.inData);
        clean = 1'b0;
        if (fif.outReady && exp_q.size() > 1) void'(exp_q.pop_front());
      end else if (fif.outReady && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic rn, input logic iv, input logic [WIDTH-1:0] d,
                     input logic ordy);
    @(negedge clk);
    rstn         = rn;
    fif.inValid  = iv;
    fif.inData   = d;
    fif.outReady = ordy;
  endtask

  initial begin
    rstn         = 1'b0;
    fif.inValid  = 1'b1;
    fif.inData   = 16'hFFFF;
    fif.outReady = 1'b0;

    // Reset with a push pending
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1);

    // Fill, then overflow
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 16'(i * 16'h1111), 1'b0);
    cyc(1'b1, 1'b1, 16'h5555, 1'b1);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);

    // Drain from full
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b1);

    // Steady push+pop at count=2
    cyc(1'b1, 1'b1, 16'h0100, 1'b0);
    cyc(1'b1, 1'b1, 16'h0101, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 16'(16'h0102 + i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b1);

    // Empty-side latency
    cyc(1'b1, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b1, 16'hABCD, 1'b1);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1);

    // Reset mid-operation with count=3 and overflow set
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'(16'h0A00 + i), 1'b0);
    cyc(1'b0, 1'b1, 16'h7777, 1'b1);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 64) != 0, 1'($urandom % 3 != 0), 16'($urandom),
          1'($urandom % 2));
    end
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);

    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
